// File: rtl/uart_bridge_pkg.sv
// Shared definitions for UART-framed block bridges: bridge FSM states, byte width
// and the default inter-byte timeout for the 48 MHz clock domain.
package uart_bridge_pkg;

  localparam int BYTE_W = 8;

  // 10 ms at 48 MHz
  localparam int DEFAULT_TIMEOUT_CYCLES = 480000;

  typedef enum logic [2:0] {
    ST_RECV,
    ST_START,
    ST_WAIT,
    ST_SEND,
    ST_SEND_HOLD
  } bridge_state_e;

endpackage

// File: rtl/uart_bridge_timer.sv
// Saturating idle counter for UART-framed blocks: counts enabled cycles since the last
// clear and flags the cycle on which the count reaches TIMEOUT_CYCLES (0 removes it).
module uart_bridge_timer
  import uart_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear_i, enable_i};
    assign expire_o      = 1'b0;
  end else begin : g_counter
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Fires on the enabled cycle that would bring the count up to TIMEOUT_CYCLES
    assign expire_o = enable_i && !clear_i && (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/uart_block_bridge.sv
// Byte-stream bridge: assembles IN_BYTES UART bytes into a block, starts the core,
// then streams the OUT_BYTES result back to the UART transmitter MSB byte first.
module uart_block_bridge
  import uart_bridge_pkg::*;
#(
  parameter int IN_BYTES       = 32,
  parameter int OUT_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_rdy,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          tx_ready,
  output logic                          tx_en,
  output logic [BYTE_W-1:0]             tx_data,
  output logic [IN_BYTES*BYTE_W-1:0]    core_din,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [OUT_BYTES*BYTE_W-1:0]   core_dout,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          overrun_err
);

  localparam int DIN_W = IN_BYTES * BYTE_W;
  localparam int SR_W  = OUT_BYTES * BYTE_W;
  localparam int RXW   = $clog2(IN_BYTES + 1);
  localparam int TXW   = $clog2(OUT_BYTES + 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(IN_BYTES - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(OUT_BYTES - 1);

  bridge_state_e     state_q, state_d;
  logic [RXW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [TXW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [DIN_W-1:0]  din_q, din_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              hold_q, hold_d;
  logic              tx_en_q, tx_en_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_err_q, overrun_err_d;
  logic              idle_run;
  logic              idle_expire;

  // Idle time only accrues inside a partial frame; any received byte restarts it
  assign idle_run = (state_q == ST_RECV) && (rx_cnt_q != '0) && !rx_rdy;

  uart_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (!idle_run),
    .enable_i(idle_run),
    .expire_o(idle_expire)
  );

  always_comb begin
    state_d       = state_q;
    rx_cnt_d      = rx_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    din_d         = din_q;
    sr_d          = sr_q;
    hold_d        = 1'b0;
    tx_en_d       = 1'b0;
    tx_data_d     = tx_data_q;
    core_start_d  = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = rx_rdy && (state_q != ST_RECV);

    unique case (state_q)
      ST_RECV: begin
        if (rx_rdy) begin
          din_d = DIN_W'({din_q, rx_data});
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_d     = '0;
            core_start_d = 1'b1;
            state_d      = ST_START;
          end else begin
            rx_cnt_d = rx_cnt_q + RXW'(1);
          end
        end else if (idle_expire) begin
          // Stale bytes stay in din_q; the next frame shifts them out
          rx_cnt_d      = '0;
          timeout_err_d = 1'b1;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          sr_d     = core_dout;
          tx_cnt_d = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_en_d   = 1'b1;
          tx_data_d = sr_q[SR_W-1 -: BYTE_W];
          hold_d    = 1'b1;
          state_d   = ST_SEND_HOLD;
        end
      end
      ST_SEND_HOLD: begin
        // hold_q masks the cycle in which tx_ready may still show the pre-load level
        if (!hold_q && tx_ready) begin
          sr_d     = sr_q << BYTE_W;
          tx_cnt_d = tx_cnt_q + TXW'(1);
          state_d  = (tx_cnt_q == TX_LAST) ? ST_RECV : ST_SEND;
        end
      end
      default: state_d = ST_RECV;
    endcase

    busy_d = (state_d != ST_RECV) || (rx_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RECV;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      din_q         <= '0;
      sr_q          <= '0;
      hold_q        <= 1'b0;
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      din_q         <= din_d;
      sr_q          <= sr_d;
      hold_q        <= hold_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign core_din    = din_q;
  assign core_start  = core_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_block_bridge.sv
// Directed bench for uart_block_bridge with 4-byte input, 2-byte output blocks and a
// 100-cycle inter-byte timeout; table-driven frames plus hand-written corner sequences.
module tb_uart_block_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b1;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [31:0] core_din;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [15:0] core_dout = '0;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] rxSeq;       // byte i is sent i-th, from rxSeq[8*i +: 8]
    logic [31:0] expDin;
    logic [15:0] coreResult;
    logic [7:0]  expTx0;
    logic [7:0]  expTx1;
  } vec_t;

  vec_t vecs [3];

  uart_block_bridge #(
    .IN_BYTES      (4),
    .OUT_BYTES     (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .core_din   (core_din),
    .core_start (core_start),
    .core_done  (core_done),
    .core_dout  (core_dout),
    .busy       (busy),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tx_en"}, 64'(tx_en), 64'h0);
    checkOutput({tag, " tx_data"}, 64'(tx_data), 64'h0);
    checkOutput({tag, " core_din"}, 64'(core_din), 64'h0);
    checkOutput({tag, " core_start"}, 64'(core_start), 64'h0);
    checkOutput({tag, " busy"}, 64'(busy), 64'h0);
    checkOutput({tag, " timeout_err"}, 64'(timeout_err), 64'h0);
    checkOutput({tag, " overrun_err"}, 64'(overrun_err), 64'h0);
  endtask

  task automatic runFrame(input string tag, input logic [31:0] seq, input logic [31:0] expDin);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(seq[8*i +: 8]);
    end
    checkOutput({tag, " core_start"}, 64'(core_start), 64'h1);
    checkOutput({tag, " core_din"}, 64'(core_din), 64'(expDin));
    tick();
    checkOutput({tag, " core_start width"}, 64'(core_start), 64'h0);
  endtask

  task automatic collectTx(output int n, output logic [7:0] b0, output logic [7:0] b1,
                           output int k0, output int k1, output int kIdle);
    n = 0; b0 = '0; b1 = '0; k0 = -1; k1 = -1; kIdle = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (tx_en) begin
        if (n == 0) begin b0 = tx_data; k0 = k; end
        else if (n == 1) begin b1 = tx_data; k1 = k; end
        n++;
      end
      if (!busy) begin
        kIdle = k;
        break;
      end
    end
  endtask

  task automatic runCore(input string tag, input logic [15:0] result, input logic [7:0] e0, input logic [7:0] e1);
    int n, k0, k1, kIdle;
    logic [7:0] b0, b1;
    tick();
    core_done = 1'b1;
    core_dout = result;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    checkOutput({tag, " tx_en early"}, 64'(tx_en), 64'h0);
    collectTx(n, b0, b1, k0, k1, kIdle);
    checkOutput({tag, " tx count"}, 64'(n), 64'd2);
    checkOutput({tag, " tx byte0"}, 64'(b0), 64'(e0));
    checkOutput({tag, " tx byte1"}, 64'(b1), 64'(e1));
    checkOutput({tag, " tx0 latency"}, 64'(k0), 64'd1);
    checkOutput({tag, " tx1 latency"}, 64'(k1), 64'd4);
    checkOutput({tag, " idle latency"}, 64'(kIdle), 64'd6);
  endtask

  initial begin
    int n, k0, k1, kIdle, kTo, pulses;
    logic [7:0] b0, b1;

    vecs[0] = '{32'h04030201, 32'h01020304, 16'hA5C3, 8'hA5, 8'hC3};
    vecs[1] = '{32'h7F8000FF, 32'hFF00807F, 16'h00FF, 8'h00, 8'hFF};
    vecs[2] = '{32'hEFBEADDE, 32'hDEADBEEF, 16'h1234, 8'h12, 8'h34};

    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      runFrame($sformatf("vec%0d", v), vecs[v].rxSeq, vecs[v].expDin);
      runCore($sformatf("vec%0d", v), vecs[v].coreResult, vecs[v].expTx0, vecs[v].expTx1);
    end

    // Partial frame abandoned: timeout after exactly 100 idle cycles, block kept stale
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    kTo = -1;
    for (int k = 1; k <= 150; k++) begin
      if (timeout_err) begin
        kTo = k;
        break;
      end
      tick();
    end
    checkOutput("timeout latency", 64'(kTo), 64'd101);
    checkOutput("timeout busy", 64'(busy), 64'h0);
    checkOutput("timeout stale din", 64'(core_din), 64'hBEEFAABB);
    tick();
    checkOutput("timeout pulse width", 64'(timeout_err), 64'h0);
    runFrame("post-timeout", 32'h13121110, 32'h10111213);
    runCore("post-timeout", 16'h5A3C, 8'h5A, 8'h3C);

    // Byte lands on the would-be expiry cycle
    applyStimulus(8'h21);
    applyStimulus(8'h22);
    repeat (99) tick();
    applyStimulus(8'h23);
    checkOutput("race no timeout", 64'(timeout_err), 64'h0);
    applyStimulus(8'h24);
    checkOutput("race core_start", 64'(core_start), 64'h1);
    checkOutput("race core_din", 64'(core_din), 64'h21222324);
    tick();
    runCore("race", 16'h0F0E, 8'h0F, 8'h0E);

    // Byte during WAIT is dropped with an overrun pulse
    runFrame("overrun", 32'h34333231, 32'h31323334);
    applyStimulus(8'h99);
    checkOutput("overrun pulse", 64'(overrun_err), 64'h1);
    tick();
    checkOutput("overrun pulse width", 64'(overrun_err), 64'h0);
    runCore("overrun", 16'h6699, 8'h66, 8'h99);
    runFrame("post-overrun", 32'h44434241, 32'h41424344);
    runCore("post-overrun", 16'h7788, 8'h77, 8'h88);

    // Spurious core_done while idle
    core_done = 1'b1;
    core_dout = 16'hFFFF;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (tx_en) pulses++;
      tick();
    end
    checkOutput("spurious done tx_en", 64'(pulses), 64'd0);
    checkOutput("spurious done busy", 64'(busy), 64'h0);

    // Transmitter stalled for 50 cycles after the result arrives
    runFrame("stall", 32'h54535251, 32'h51525354);
    tx_ready = 1'b0;
    tick();
    core_done = 1'b1;
    core_dout = 16'hBEEF;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_en) pulses++;
      tick();
    end
    checkOutput("stall no tx_en", 64'(pulses), 64'd0);
    tx_ready = 1'b1;
    tick();
    checkOutput("stall release tx_en", 64'(tx_en), 64'h1);
    checkOutput("stall release tx_data", 64'(tx_data), 64'hBE);
    collectTx(n, b0, b1, k0, k1, kIdle);
    checkOutput("stall remaining count", 64'(n), 64'd1);
    checkOutput("stall byte1", 64'(b0), 64'hEF);
    checkOutput("stall tx1 spacing", 64'(k0), 64'd3);
    checkOutput("stall idle latency", 64'(kIdle), 64'd5);

    // Reset in the middle of sending the result
    runFrame("midreset", 32'h64636261, 32'h61626364);
    tick();
    core_done = 1'b1;
    core_dout = 16'h1357;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    tick();
    checkOutput("midreset tx_en", 64'(tx_en), 64'h1);
    checkOutput("midreset tx_data", 64'(tx_data), 64'h13);
    rst = 1'b1;
    tick();
    checkAllZero("midreset");
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tx_en) pulses++;
    end
    checkOutput("midreset lost byte", 64'(pulses), 64'd0);
    runFrame("post-reset", 32'h74737271, 32'h71727374);
    runCore("post-reset", 16'h2468, 8'h24, 8'h68);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
